// File: rtl/exe_mem_stage_buffer.sv
// EXE->MEM pipeline register: 2-entry skid buffer for ALU results plus the
// architectural NZCV register, whose carry bit feeds back to the ALU.
module exe_mem_stage_buffer #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_alu_result,
    input  logic [3:0]            in_status,
    input  logic                  in_s,
    input  logic                  in_wb_en,
    input  logic                  in_mem_r_en,
    input  logic                  in_mem_w_en,
    input  logic [REG_ADDR_W-1:0] in_dest,
    input  logic [DATA_W-1:0]     in_store_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_alu_result,
    output logic                  out_wb_en,
    output logic                  out_mem_r_en,
    output logic                  out_mem_w_en,
    output logic [REG_ADDR_W-1:0] out_dest,
    output logic [DATA_W-1:0]     out_store_data,
    output logic [3:0]            status,
    output logic                  carry_flag
);

    typedef struct packed {
        logic [DATA_W-1:0]     alu_result;
        logic                  wb_en;
        logic                  mem_r_en;
        logic                  mem_w_en;
        logic [REG_ADDR_W-1:0] dest;
        logic [DATA_W-1:0]     store_data;
    } entry_t;

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    state_t state_q, state_d;
    entry_t head_q, skid_q, in_entry;
    logic   acc, pop;
    logic   load_head_in, load_head_skid, load_skid;

    // in_ready decodes straight from the state register, so there is no
    // combinational path from out_ready back upstream.
    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign acc       = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready;

    assign in_entry = '{alu_result: in_alu_result, wb_en: in_wb_en,
                        mem_r_en: in_mem_r_en, mem_w_en: in_mem_w_en,
                        dest: in_dest, store_data: in_store_data};

    always_comb begin
        state_d        = state_q;
        load_head_in   = 1'b0;
        load_head_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: if (acc) begin
                    state_d      = ONE;
                    load_head_in = 1'b1;
                end
                ONE: begin
                    if (acc && pop) begin
                        load_head_in = 1'b1;
                    end else if (acc) begin
                        state_d   = FULL;
                        load_skid = 1'b1;
                    end else if (pop) begin
                        state_d = EMPTY;
                    end
                end
                FULL: if (pop) begin
                    state_d        = ONE;
                    load_head_skid = 1'b1;
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= EMPTY;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_head_in)        head_q <= in_entry;
            else if (load_head_skid) head_q <= skid_q;
            if (load_skid)           skid_q <= in_entry;
        end
    end

    // Flags follow accepted instructions, independent of MEM consumption.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          status <= 4'b0000;
        else if (acc & in_s) status <= in_status;
    end

    assign carry_flag     = status[1];
    assign out_alu_result = head_q.alu_result;
    assign out_wb_en      = head_q.wb_en;
    assign out_mem_r_en   = head_q.mem_r_en;
    assign out_mem_w_en   = head_q.mem_w_en;
    assign out_dest       = head_q.dest;
    assign out_store_data = head_q.store_data;

endmodule

// File: tb/tb_exe_mem_stage_buffer.sv
// Bench for exe_mem_stage_buffer: directed vector table, async-reset corner,
// then random traffic against a 2-deep FIFO + flag register model.
module tb_exe_mem_stage_buffer;

    logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
    logic        in_valid = 1'b0, in_ready;
    logic [31:0] in_alu_result = '0, in_store_data = '0;
    logic [3:0]  in_status = '0, in_dest = '0;
    logic        in_s = 1'b0, in_wb_en = 1'b0, in_mem_r_en = 1'b0, in_mem_w_en = 1'b0;
    logic        out_valid, out_ready = 1'b0;
    logic [31:0] out_alu_result, out_store_data;
    logic        out_wb_en, out_mem_r_en, out_mem_w_en;
    logic [3:0]  out_dest, status;
    logic        carry_flag;

    int total = 0, bad = 0;

    exe_mem_stage_buffer #(.DATA_W(32), .REG_ADDR_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_alu_result(in_alu_result), .in_status(in_status), .in_s(in_s),
        .in_wb_en(in_wb_en), .in_mem_r_en(in_mem_r_en), .in_mem_w_en(in_mem_w_en),
        .in_dest(in_dest), .in_store_data(in_store_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_alu_result(out_alu_result), .out_wb_en(out_wb_en),
        .out_mem_r_en(out_mem_r_en), .out_mem_w_en(out_mem_w_en),
        .out_dest(out_dest), .out_store_data(out_store_data),
        .status(status), .carry_flag(carry_flag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        vld;
        logic [31:0] res;
        logic [3:0]  dest;
        logic        s;
        logic [3:0]  st;
        logic        ordy;
        logic        fl;
        logic        e_ov;
        logic        e_ir;
        logic [31:0] e_res;
        logic [3:0]  e_dest;
        logic [3:0]  e_st;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  dest;
        logic        wb, r, w;
        logic [31:0] sd;
    } ent_t;

    function automatic vec_t mk(logic vld, logic [31:0] res, logic [3:0] dest, logic s,
                                logic [3:0] st, logic ordy, logic fl, logic e_ov, logic e_ir,
                                logic [31:0] e_res, logic [3:0] e_dest, logic [3:0] e_st);
        vec_t v;
        v.vld = vld; v.res = res; v.dest = dest; v.s = s; v.st = st; v.ordy = ordy;
        v.fl = fl; v.e_ov = e_ov; v.e_ir = e_ir; v.e_res = e_res; v.e_dest = e_dest;
        v.e_st = e_st;
        return v;
    endfunction

    task automatic drive(input logic vld, input logic [31:0] res, input logic [3:0] dest,
                         input logic s, input logic [3:0] st, input logic ordy, input logic fl);
        in_valid = vld; in_alu_result = res; in_dest = dest; in_s = s; in_status = st;
        out_ready = ordy; flush = fl;
        in_store_data = res ^ 32'hFFFF_0000;
        in_wb_en = 1'b1; in_mem_r_en = res[0]; in_mem_w_en = res[1];
    endtask

    vec_t vt[16];
    ent_t q[$];
    ent_t e;
    logic [3:0] mst;
    logic macc, mpop;

    initial begin
        // Directed sequence: each row is inputs before an edge and outputs after it.
        vt[0]  = mk(1, 32'h5,  4'd3, 0, 4'b0000, 1, 0, 1, 1, 32'h5,  4'd3, 4'b0000);
        vt[1]  = mk(0, 32'h0,  4'd0, 0, 4'b0000, 1, 0, 0, 1, 32'h0,  4'd0, 4'b0000);
        vt[2]  = mk(1, 32'h10, 4'd1, 1, 4'b0110, 1, 0, 1, 1, 32'h10, 4'd1, 4'b0110);
        vt[3]  = mk(1, 32'h20, 4'd2, 0, 4'b1001, 1, 0, 1, 1, 32'h20, 4'd2, 4'b0110);
        vt[4]  = mk(0, 32'h0,  4'd0, 0, 4'b0000, 1, 0, 0, 1, 32'h0,  4'd0, 4'b0110);
        vt[5]  = mk(1, 32'hA,  4'd4, 0, 4'b0000, 0, 0, 1, 1, 32'hA,  4'd4, 4'b0110);
        vt[6]  = mk(1, 32'hB,  4'd5, 0, 4'b0000, 0, 0, 1, 0, 32'hA,  4'd4, 4'b0110);
        vt[7]  = mk(1, 32'hC,  4'd6, 1, 4'b1111, 0, 0, 1, 0, 32'hA,  4'd4, 4'b0110);
        vt[8]  = mk(1, 32'hC,  4'd6, 0, 4'b0000, 1, 0, 1, 1, 32'hB,  4'd5, 4'b0110);
        vt[9]  = mk(1, 32'hC,  4'd6, 0, 4'b0000, 1, 0, 1, 1, 32'hC,  4'd6, 4'b0110);
        vt[10] = mk(0, 32'h0,  4'd0, 0, 4'b0000, 1, 0, 0, 1, 32'h0,  4'd0, 4'b0110);
        vt[11] = mk(1, 32'hD,  4'd7, 1, 4'b0001, 0, 0, 1, 1, 32'hD,  4'd7, 4'b0001);
        vt[12] = mk(1, 32'hE,  4'd8, 0, 4'b0000, 0, 0, 1, 0, 32'hD,  4'd7, 4'b0001);
        vt[13] = mk(1, 32'h77, 4'd9, 1, 4'b1000, 1, 1, 0, 1, 32'h0,  4'd0, 4'b0001);
        vt[14] = mk(1, 32'hF,  4'd9, 1, 4'b1111, 0, 0, 1, 1, 32'hF,  4'd9, 4'b1111);
        vt[15] = mk(1, 32'h66, 4'd2, 1, 4'b0010, 1, 1, 0, 1, 32'h0,  4'd0, 4'b1111);

        #12;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_in_ready", in_ready, 1);
        chk("reset_result", out_alu_result, 0);
        chk("reset_dest", out_dest, 0);
        chk("reset_status", status, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            drive(vt[i].vld, vt[i].res, vt[i].dest, vt[i].s, vt[i].st, vt[i].ordy, vt[i].fl);
            @(posedge clk); #1;
            chk($sformatf("vec%0d_out_valid", i), out_valid, vt[i].e_ov);
            chk($sformatf("vec%0d_in_ready", i), in_ready, vt[i].e_ir);
            chk($sformatf("vec%0d_status", i), status, vt[i].e_st);
            chk($sformatf("vec%0d_carry", i), carry_flag, vt[i].e_st[1]);
            if (vt[i].e_ov) begin
                chk($sformatf("vec%0d_result", i), out_alu_result, vt[i].e_res);
                chk($sformatf("vec%0d_dest", i), out_dest, vt[i].e_dest);
                chk($sformatf("vec%0d_store", i), out_store_data, vt[i].e_res ^ 32'hFFFF_0000);
            end
        end

        // Fill to FULL with flags set, then reset between edges.
        drive(1, 32'h1, 4'd1, 1, 4'b1111, 0, 0);
        @(posedge clk); #1;
        drive(1, 32'h2, 4'd2, 0, 4'b0000, 0, 0);
        @(posedge clk); #1;
        chk("full_in_ready", in_ready, 0);
        drive(0, 32'h0, 4'd0, 0, 4'b0000, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", out_valid, 0);
        chk("async_rst_status", status, 0);
        chk("async_rst_in_ready", in_ready, 1);
        #1 rst_n = 1'b1;

        // Random traffic vs. capacity-2 FIFO model.
        mst = 4'b0000;
        for (int i = 0; i < 400; i++) begin
            in_valid      = ($urandom_range(0, 9) < 7);
            out_ready     = ($urandom_range(0, 9) < 6);
            flush         = ($urandom_range(0, 11) == 0);
            in_s          = $urandom_range(0, 1);
            in_status     = 4'($urandom);
            in_alu_result = $urandom;
            in_store_data = $urandom;
            in_dest       = 4'($urandom);
            in_wb_en      = $urandom_range(0, 1);
            in_mem_r_en   = $urandom_range(0, 1);
            in_mem_w_en   = $urandom_range(0, 1);
            macc = in_valid && (q.size() < 2) && !flush;
            mpop = (q.size() > 0) && out_ready;
            e.res = in_alu_result; e.dest = in_dest; e.wb = in_wb_en;
            e.r = in_mem_r_en; e.w = in_mem_w_en; e.sd = in_store_data;
            @(posedge clk); #1;
            if (flush) q.delete();
            else begin
                if (mpop) void'(q.pop_front());
                if (macc) q.push_back(e);
            end
            if (macc && in_s) mst = in_status;
            chk("rnd_out_valid", out_valid, q.size() > 0);
            chk("rnd_in_ready", in_ready, q.size() < 2);
            chk("rnd_status", status, mst);
            chk("rnd_carry", carry_flag, mst[1]);
            if (q.size() > 0) begin
                chk("rnd_result", out_alu_result, q[0].res);
                chk("rnd_dest", out_dest, q[0].dest);
                chk("rnd_store", out_store_data, q[0].sd);
                chk("rnd_ctl", {out_wb_en, out_mem_r_en, out_mem_w_en}, {q[0].wb, q[0].r, q[0].w});
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/exe_mem_stage_buffer.md
Name: exe_mem_stage_buffer

Overview:
- Sits directly downstream of the ALU. Captures each executed instruction's ALU result, control bits and store data into a 2-entry skid buffer that feeds the memory stage.
- Owns the architectural NZCV status register, loaded from the ALU status output when an S-flagged instruction is accepted.
- The registered carry flag feeds back to the ALU carry input for ADC/SBC.

Parameters:
- DATA_W, 32, width of ALU result and store data.
- REG_ADDR_W, 4, width of destination register index.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  pipeline flush (branch taken); kills buffered and incoming entries.
- in_valid  in  1  EXE stage presents an instruction.
- in_ready  out  1  buffer can accept this cycle.
- in_alu_result  in  DATA_W  ALU result.
- in_status  in  4  ALU status {N,Z,C,V}.
- in_s  in  1  instruction updates flags.
- in_wb_en  in  1  writeback enable.
- in_mem_r_en  in  1  load.
- in_mem_w_en  in  1  store.
- in_dest  in  REG_ADDR_W  destination register.
- in_store_data  in  DATA_W  Rm value for stores.
- out_valid  out  1  entry presented to MEM stage.
- out_ready  in  1  MEM stage consumes this cycle.
- out_alu_result, out_wb_en, out_mem_r_en, out_mem_w_en, out_dest, out_store_data  out  (as inputs)  head-entry fields.
- status  out  4  architectural NZCV register {N,Z,C,V}.
- carry_flag  out  1  equals status[1]; drives the ALU carry input.

Behaviour:
- Reset (rst_n low, asynchronous): both entries invalid, out_valid=0, in_ready=1, all out_* fields=0, status=4'b0000.
- Accept condition: acc = in_valid & in_ready & ~flush.
- Consume condition: pop = out_valid & out_ready.
- States by occupancy:
  - EMPTY: out_valid=0, in_ready=1. acc moves to ONE; entry appears on out_* next cycle (latency 1).
  - ONE: out_valid=1, in_ready=1.
    - acc & pop: stays ONE, head replaced by the new entry. This gives 1/cycle throughput.
    - acc & ~pop: goes to FULL; new entry goes to the skid slot.
    - ~acc & pop: goes to EMPTY.
  - FULL: out_valid=1, in_ready=0.
    - pop: skid entry moves to head, state goes to ONE.
- in_ready is driven from a register and equals ~skid_valid. It has no combinational path from out_ready.
- Head fields stay stable while out_valid=1 & ~out_ready.
- Flush:
  - At the edge, both entries are invalidated and the state goes to EMPTY.
  - An in_valid present in the same cycle is dropped.
  - A simultaneous pop is a don't-care for the MEM stage: MEM ignores it under flush.
- Status update:
  - On an edge with acc & in_s, status <= in_status; the new value is visible the cycle after acceptance.
  - Without acc, or with in_s=0, status holds.
  - A flushed or stalled (in_ready=0) instruction never updates status.
  - Status is not cleared by flush.
- Status and data are independent: status tracks accepted instructions, not MEM consumption.
- Mid-operation reset clears entries and status immediately, regardless of clk.

Test Plan:
- Reset, then single ADD (in_alu_result=32'h5, in_s=0, in_dest=3, out_ready=1) -> next cycle out_valid=1, out_alu_result=5, out_dest=3; following cycle out_valid=0; status=0000.
- Back-to-back 4 instructions with out_ready=1 -> one emitted per cycle in order; in_ready stays 1.
- out_ready=0 while sending results A, B, C -> A at head, B in skid, in_ready=0 after B, C held upstream. Raising out_ready -> A, B, C emitted in order with no loss or duplication.
- SUBS with in_status=4'b0110, in_s=1 -> status=0110 and carry_flag=1 next cycle. Following ADD with in_s=0 and in_status=1001 -> status stays 0110.
- FULL buffer plus flush together with in_valid & in_s=1 (in_status=1000) -> next cycle out_valid=0, in_ready=1, status unchanged.
- Assert rst_n low asynchronously between clock edges while in FULL -> out_valid and status drop to 0 before the next clk edge.
